// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace-packet assembler slice.
//   trdb_format_e           : top-level packet format (F0..F3)
//   trdb_f_sync_subformat_e : F3 subformat (start, exception, context, support)
//   map_len()               : branch count -> branch-map field width for F1
package trdb_pkg;

    typedef enum logic [1:0] {
        FORMAT_F0 = 2'd0,
        FORMAT_F1 = 2'd1,
        FORMAT_F2 = 2'd2,
        FORMAT_F3 = 2'd3
    } trdb_format_e;

    typedef enum logic [1:0] {
        SF_START     = 2'd0,
        SF_EXCEPTION = 2'd1,
        SF_CONTEXT   = 2'd2,
        SF_SUPPORT   = 2'd3
    } trdb_f_sync_subformat_e;

    localparam int FORMAT_W    = 2;
    localparam int SUBFORMAT_W = 2;
    localparam int BRANCHES_W  = 5;
    localparam int MAP_W       = 31;
    localparam int QUAL_W      = 2;
    localparam int MAP_LEN_W   = 6;

    // Branch maps are emitted in buckets of 1, 9, 17, 25 or 31 bits.
    function automatic logic [MAP_LEN_W-1:0] map_len(input logic [BRANCHES_W-1:0] branches);
        if (branches == 5'd0)       return 6'd0;
        else if (branches == 5'd1)  return 6'd1;
        else if (branches <= 5'd9)  return 6'd9;
        else if (branches <= 5'd17) return 6'd17;
        else if (branches <= 5'd25) return 6'd25;
        else                        return 6'd31;
    endfunction

endpackage

// File: rtl/trdb_packet_assembler_if.sv
// Packet stream between the assembler and the encapsulator.
//   valid   : head entry present        (master -> slave)
//   ready   : slave accepts head entry  (slave -> master)
//   payload : packed packet, LSB-first, zero above the length
//   len     : payload length in bytes
interface trdb_packet_assembler_if #(
    parameter int PAYLOAD_W = 128,
    parameter int LEN_W     = $clog2(PAYLOAD_W / 8 + 1)
);
    logic                 valid;
    logic                 ready;
    logic [PAYLOAD_W-1:0] payload;
    logic [LEN_W-1:0]     len;

    modport master (output valid, payload, len, input ready);
    modport slave  (input valid, payload, len, output ready);
endinterface

// File: rtl/trdb_pkt_fifo.sv
// Small synchronous FIFO holding assembled packets.
//   push_i/data_i/full_o : write side; a push while full is only taken with a pop
//   pop_i/valid_o/data_o : read side; data_o is the stored head, zero when empty
// A write becomes visible on the read side the cycle after it is pushed.
module trdb_pkt_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 133
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             full_o,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (PTR_W + 1)'(DEPTH));
    assign valid_o = (count_q != '0);
    assign do_pop  = pop_i & valid_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        end
    end

    // NOTE: storage is not reset; entries are only observable through valid_o,
    // and the read mux forces zero while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule

// File: rtl/trdb_packet_assembler.sv
// Packs E-trace payloads (F1, F2, F3 SF0/SF1/SF3) and queues them for the
// packet encapsulator.
//   clk_i, rst_ni              : clock, asynchronous active-low reset
//   req_valid_i / req_ready_o  : request handshake from the filter/priority logic
//   format_i .. branch_map_i   : packet fields, sampled on acceptance
//   pkt                        : packet stream (valid/ready/payload/len)
//   branch_map_flush_o         : one-cycle pulse after a branch map is consumed
module trdb_packet_assembler
    import trdb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int PRIV_LEN   = 2,
    parameter int CAUSE_LEN  = 5,
    parameter int IOPT_W     = 4,
    parameter int PAYLOAD_W  = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  trdb_format_e           format_i,
    input  trdb_f_sync_subformat_e subformat_i,
    input  logic                   full_address_i,
    input  logic                   addr_needed_i,
    input  logic                   branch_i,
    input  logic [PRIV_LEN-1:0]    priv_i,
    input  logic [XLEN-1:0]        iaddr_i,
    input  logic [CAUSE_LEN-1:0]   ecause_i,
    input  logic                   interrupt_i,
    input  logic                   thaddr_i,
    input  logic [XLEN-1:0]        tval_i,
    input  logic                   ienable_i,
    input  logic                   encoder_mode_i,
    input  logic [QUAL_W-1:0]      qual_status_i,
    input  logic [IOPT_W-1:0]      ioptions_i,
    input  logic                   notify_i,
    input  logic                   updiscon_i,
    input  logic [BRANCHES_W-1:0]  branches_i,
    input  logic [MAP_W-1:0]       branch_map_i,
    trdb_packet_assembler_if.master pkt,
    output logic                   branch_map_flush_o
);
    localparam int LEN_W  = $clog2(PAYLOAD_W / 8 + 1);
    localparam int POS_W  = $clog2(PAYLOAD_W + 1);
    localparam int NBYTES = PAYLOAD_W / 8;

    localparam int F3_SF0_BITS   = FORMAT_W + SUBFORMAT_W + 1 + PRIV_LEN + XLEN;
    localparam int F3_SF1_BITS   = F3_SF0_BITS + CAUSE_LEN + 2 + XLEN;
    localparam int F3_SF3_BITS   = FORMAT_W + SUBFORMAT_W + 2 + QUAL_W + IOPT_W;
    localparam int F2_BITS       = FORMAT_W + XLEN + 2;
    localparam int F1_FIXED_BITS = FORMAT_W + BRANCHES_W + XLEN + 2;
    localparam int F1_NOADDR_BITS = FORMAT_W + BRANCHES_W + MAP_W;

    logic [XLEN-1:0]      latest_addr_q, addr;
    logic [PAYLOAD_W-1:0] pack;
    logic [POS_W-1:0]     pack_bits;
    logic [LEN_W-1:0]     byte_len;
    logic [MAP_LEN_W-1:0] map_bits;
    logic [MAP_W-1:0]     map_mask;
    logic                 supported, compress, updates_addr, flush_d, fits;
    logic                 accept, fifo_full, flush_q;
    logic [LEN_W+PAYLOAD_W-1:0] fifo_out;

    // A full FIFO still accepts when the head leaves in the same cycle.
    assign req_ready_o = ~fifo_full | pkt.ready;
    assign accept      = req_valid_i & req_ready_o;

    assign addr     = full_address_i ? iaddr_i : iaddr_i - latest_addr_q;
    assign map_bits = map_len(branches_i);
    assign map_mask = MAP_W'((32'd1 << map_bits) - 32'd1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        pack         = '0;
        pack_bits    = '0;
        supported    = 1'b0;
        compress     = 1'b0;
        updates_addr = 1'b0;
        flush_d      = 1'b0;
        case (format_i)
            FORMAT_F3: begin
                case (subformat_i)
                    SF_START: begin
                        pack         = PAYLOAD_W'({iaddr_i, priv_i, branch_i, subformat_i, format_i});
                        pack_bits    = POS_W'(F3_SF0_BITS);
                        supported    = 1'b1;
                        updates_addr = 1'b1;
                        flush_d      = 1'b1;
                    end
                    SF_EXCEPTION: begin
                        pack = PAYLOAD_W'({tval_i, iaddr_i, thaddr_i, interrupt_i, ecause_i,
                                           priv_i, branch_i, subformat_i, format_i});
                        pack_bits    = POS_W'(F3_SF1_BITS);
                        supported    = 1'b1;
                        updates_addr = 1'b1;
                        flush_d      = 1'b1;
                    end
                    SF_SUPPORT: begin
                        pack = PAYLOAD_W'({ioptions_i, qual_status_i, encoder_mode_i, ienable_i,
                                           subformat_i, format_i});
                        pack_bits = POS_W'(F3_SF3_BITS);
                        supported = 1'b1;
                    end
                    default: begin end
                endcase
            end
            FORMAT_F2: begin
                pack         = PAYLOAD_W'({updiscon_i, notify_i, addr, format_i});
                pack_bits    = POS_W'(F2_BITS);
                supported    = 1'b1;
                compress     = 1'b1;
                updates_addr = 1'b1;
            end
            FORMAT_F1: begin
                supported = 1'b1;
                compress  = 1'b1;
                flush_d   = 1'b1;
                if (addr_needed_i) begin
                    // The address/flag tail starts right after the variable-width map.
                    pack = PAYLOAD_W'({branches_i, format_i})
                         | (PAYLOAD_W'(branch_map_i & map_mask) << (FORMAT_W + BRANCHES_W))
                         | (PAYLOAD_W'({updiscon_i, notify_i, addr})
                            << (POS_W'(FORMAT_W + BRANCHES_W) + POS_W'(map_bits)));
                    pack_bits    = POS_W'(F1_FIXED_BITS) + POS_W'(map_bits);
                    updates_addr = 1'b1;
                end else begin
                    pack      = PAYLOAD_W'({branch_map_i, BRANCHES_W'(0), format_i});
                    pack_bits = POS_W'(F1_NOADDR_BITS);
                end
            end
            default: begin end
        endcase
    end

    // F1/F2 drop every upper byte that is pure sign extension of the byte below;
    // scanning from the top down leaves the smallest length that still fits.
    always_comb begin
        byte_len = LEN_W'((int'(pack_bits) + 7) / 8);
        fits     = 1'b0;
        if (compress) begin
            for (int n = NBYTES; n >= 1; n--) begin
                fits = 1'b1;
                for (int b = 0; b < PAYLOAD_W; b++) begin
                    if (b >= 8 * n && b < int'(pack_bits) && pack[b] != pack[8*n-1])
                        fits = 1'b0;
                end
                if (fits) byte_len = LEN_W'(n);
            end
        end
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            latest_addr_q <= '0;
            flush_q       <= 1'b0;
        end else begin
            flush_q <= accept & flush_d;
            if (accept & updates_addr) latest_addr_q <= iaddr_i;
        end
    end

    assign branch_map_flush_o = flush_q;

    trdb_pkt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (LEN_W + PAYLOAD_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (accept & supported),
        .data_i  ({byte_len, pack}),
        .full_o  (fifo_full),
        .pop_i   (pkt.ready),
        .valid_o (pkt.valid),
        .data_o  (fifo_out)
    );

    assign pkt.payload = fifo_out[PAYLOAD_W-1:0];
    assign pkt.len     = fifo_out[PAYLOAD_W +: LEN_W];
endmodule

// File: tb/tb_trdb_packet_assembler.sv
// Self-checking bench for trdb_packet_assembler.
module tb_trdb_packet_assembler;
    import trdb_pkg::*;

    localparam int PAYLOAD_W = 128;
    localparam int LEN_W     = 5;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic                   req_valid_i, req_ready_o;
    trdb_format_e           format_i;
    trdb_f_sync_subformat_e subformat_i;
    logic full_address_i, addr_needed_i, branch_i, interrupt_i, thaddr_i;
    logic ienable_i, encoder_mode_i, notify_i, updiscon_i, branch_map_flush_o;
    logic [1:0]  priv_i, qual_status_i;
    logic [31:0] iaddr_i, tval_i;
    logic [4:0]  ecause_i, branches_i;
    logic [3:0]  ioptions_i;
    logic [30:0] branch_map_i;

    trdb_packet_assembler_if #(.PAYLOAD_W(PAYLOAD_W)) pkt_if ();

    trdb_packet_assembler dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .format_i(format_i), .subformat_i(subformat_i),
        .full_address_i(full_address_i), .addr_needed_i(addr_needed_i),
        .branch_i(branch_i), .priv_i(priv_i), .iaddr_i(iaddr_i),
        .ecause_i(ecause_i), .interrupt_i(interrupt_i), .thaddr_i(thaddr_i),
        .tval_i(tval_i), .ienable_i(ienable_i), .encoder_mode_i(encoder_mode_i),
        .qual_status_i(qual_status_i), .ioptions_i(ioptions_i),
        .notify_i(notify_i), .updiscon_i(updiscon_i),
        .branches_i(branches_i), .branch_map_i(branch_map_i),
        .pkt(pkt_if), .branch_map_flush_o(branch_map_flush_o)
    );

    typedef struct packed {
        logic [1:0]  fmt, sf;
        logic        full_addr, addr_needed, branch;
        logic [1:0]  priv;
        logic [31:0] iaddr;
        logic [4:0]  ecause;
        logic        interrupt, thaddr;
        logic [31:0] tval;
        logic        ienable, enc_mode;
        logic [1:0]  qual;
        logic [3:0]  iopt;
        logic        notify, updiscon;
        logic [4:0]  branches;
        logic [30:0] map;
        logic        exp_push, exp_flush;
        logic [4:0]  exp_len;
    } vec_t;

    typedef struct packed {
        logic [PAYLOAD_W-1:0] payload;
        logic [LEN_W-1:0]     len;
    } exp_t;

    exp_t        sb_q[$];
    vec_t        vecs[11];
    logic [31:0] latest_m = '0;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [PAYLOAD_W-1:0] act,
                         input logic [PAYLOAD_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] fmt, input logic [1:0] sf);
        vec_t v;
        v = '0;
        v.fmt = fmt;
        v.sf = sf;
        v.exp_push = 1'b1;
        return v;
    endfunction

    function automatic void app(inout logic [PAYLOAD_W-1:0] p, inout int pos,
                                input logic [63:0] val, input int w);
        for (int b = 0; b < w; b++) p[pos+b] = val[b];
        pos += w;
    endfunction

    function automatic int ref_map_len(input int b);
        int m;
        if (b == 0) return 0;
        if (b == 1) return 1;
        m = ((b - 2) / 8) * 8 + 9;
        return (m > 31) ? 31 : m;
    endfunction

    // Reference packer: appends fields one bit at a time, then works out the
    // sign-compressed length from the last bit transition.
    function automatic void model(input vec_t v, input logic [31:0] latest,
                                  output logic [PAYLOAD_W-1:0] p, output logic [LEN_W-1:0] len);
        int pos, k, n, full;
        logic [31:0] a;
        p = '0;
        pos = 0;
        a = v.full_addr ? v.iaddr : v.iaddr - latest;
        app(p, pos, 64'(v.fmt), 2);
        if (v.fmt == 2'd3) begin
            app(p, pos, 64'(v.sf), 2);
            if (v.sf == 2'd0) begin
                app(p, pos, 64'(v.branch), 1); app(p, pos, 64'(v.priv), 2);
                app(p, pos, 64'(v.iaddr), 32);
            end else if (v.sf == 2'd1) begin
                app(p, pos, 64'(v.branch), 1); app(p, pos, 64'(v.priv), 2);
                app(p, pos, 64'(v.ecause), 5); app(p, pos, 64'(v.interrupt), 1);
                app(p, pos, 64'(v.thaddr), 1); app(p, pos, 64'(v.iaddr), 32);
                app(p, pos, 64'(v.tval), 32);
            end else begin
                app(p, pos, 64'(v.ienable), 1); app(p, pos, 64'(v.enc_mode), 1);
                app(p, pos, 64'(v.qual), 2); app(p, pos, 64'(v.iopt), 4);
            end
            len = LEN_W'((pos + 7) / 8);
        end else begin
            if (v.fmt == 2'd1 && !v.addr_needed) begin
                app(p, pos, 64'(0), 5); app(p, pos, 64'(v.map), 31);
            end else begin
                if (v.fmt == 2'd1) begin
                    app(p, pos, 64'(v.branches), 5);
                    app(p, pos, 64'(v.map), ref_map_len(int'(v.branches)));
                end
                app(p, pos, 64'(a), 32); app(p, pos, 64'(v.notify), 1);
                app(p, pos, 64'(v.updiscon), 1);
            end
            k = 0;
            for (int i = 1; i < pos; i++) if (p[i] !== p[i-1]) k = i;
            n = (k + 8) / 8;
            full = (pos + 7) / 8;
            if (n > full) n = full;
            len = LEN_W'(n);
        end
    endfunction

    task automatic drive(input vec_t v);
        format_i       = trdb_format_e'(v.fmt);
        subformat_i    = trdb_f_sync_subformat_e'(v.sf);
        full_address_i = v.full_addr;   addr_needed_i = v.addr_needed;
        branch_i       = v.branch;      priv_i        = v.priv;
        iaddr_i        = v.iaddr;       ecause_i      = v.ecause;
        interrupt_i    = v.interrupt;   thaddr_i      = v.thaddr;
        tval_i         = v.tval;        ienable_i     = v.ienable;
        encoder_mode_i = v.enc_mode;    qual_status_i = v.qual;
        ioptions_i     = v.iopt;        notify_i      = v.notify;
        updiscon_i     = v.updiscon;    branches_i    = v.branches;
        branch_map_i   = v.map;
    endtask

    task automatic expect_pkt(input vec_t v, input bit table_len);
        exp_t e;
        model(v, latest_m, e.payload, e.len);
        if (table_len) e.len = v.exp_len;
        sb_q.push_back(e);
    endtask

    function automatic void update_latest(input vec_t v);
        if ((v.fmt == 2'd3 && (v.sf == 2'd0 || v.sf == 2'd1)) || v.fmt == 2'd2 ||
            (v.fmt == 2'd1 && v.addr_needed))
            latest_m = v.iaddr;
    endfunction

    task automatic wait_drain();
        for (int c = 0; c < 20 && sb_q.size() != 0; c++) @(posedge clk_i);
        #1 check("drain_queue_empty", PAYLOAD_W'(sb_q.size()), '0);
    endtask

    // Scoreboard monitor: compare every packet the encapsulator takes.
    always @(negedge clk_i) begin
        if (rst_ni && pkt_if.valid && pkt_if.ready) begin
            check("pkt_expected", PAYLOAD_W'(sb_q.size() > 0), PAYLOAD_W'(1));
            if (sb_q.size() > 0) begin
                exp_t e;
                e = sb_q.pop_front();
                check("pkt_payload", pkt_if.payload, e.payload);
                check("pkt_len", PAYLOAD_W'(pkt_if.len), PAYLOAD_W'(e.len));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        vecs[0] = mk(2'd3, 2'd0); vecs[0].branch = 1; vecs[0].priv = 2'd3;
        vecs[0].iaddr = 32'h8000_0000; vecs[0].exp_len = 5; vecs[0].exp_flush = 1;
        vecs[1] = mk(2'd2, 2'd0); vecs[1].full_addr = 1; vecs[1].iaddr = 32'h1000;
        vecs[1].exp_len = 2;
        vecs[2] = mk(2'd2, 2'd0); vecs[2].iaddr = 32'h1010; vecs[2].exp_len = 1;
        vecs[3] = mk(2'd1, 2'd0); vecs[3].addr_needed = 1; vecs[3].branches = 5;
        vecs[3].map = 31'b10110; vecs[3].iaddr = 32'h1000; vecs[3].notify = 1;
        vecs[3].updiscon = 1; vecs[3].exp_len = 3; vecs[3].exp_flush = 1;
        vecs[4] = mk(2'd1, 2'd0); vecs[4].branches = 31; vecs[4].map = 31'h40AB_CDEF;
        vecs[4].iaddr = 32'hFFFF_0000; vecs[4].exp_len = 5; vecs[4].exp_flush = 1;
        vecs[5] = mk(2'd2, 2'd0); vecs[5].iaddr = 32'h1008; vecs[5].exp_len = 1;
        vecs[6] = mk(2'd3, 2'd1); vecs[6].priv = 2'd1; vecs[6].ecause = 5'd5;
        vecs[6].interrupt = 1; vecs[6].iaddr = 32'h2000; vecs[6].tval = 32'hDEAD_BEEF;
        vecs[6].exp_len = 10; vecs[6].exp_flush = 1;
        vecs[7] = mk(2'd3, 2'd3); vecs[7].ienable = 1; vecs[7].qual = 2'd2;
        vecs[7].iopt = 4'hA; vecs[7].exp_len = 2;
        vecs[8] = mk(2'd0, 2'd0); vecs[8].iaddr = 32'h9999; vecs[8].exp_push = 0;
        vecs[9] = mk(2'd3, 2'd2); vecs[9].iaddr = 32'h7777; vecs[9].exp_push = 0;
        vecs[10] = mk(2'd2, 2'd0); vecs[10].iaddr = 32'h2004; vecs[10].exp_len = 1;

        req_valid_i = 0;
        pkt_if.ready = 1;
        drive('0);
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_pkt_valid", PAYLOAD_W'(pkt_if.valid), '0);
        check("rst_payload", pkt_if.payload, '0);
        check("rst_len", PAYLOAD_W'(pkt_if.len), '0);
        check("rst_flush", PAYLOAD_W'(branch_map_flush_o), '0);
        check("rst_req_ready", PAYLOAD_W'(req_ready_o), PAYLOAD_W'(1));
        rst_ni = 1;
        @(posedge clk_i); #1;

        // Table-driven vectors, one request per cycle.
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i]);
            req_valid_i = 1;
            if (vecs[i].exp_push) expect_pkt(vecs[i], 1'b1);
            #1 check($sformatf("req_ready[%0d]", i), PAYLOAD_W'(req_ready_o), PAYLOAD_W'(1));
            @(posedge clk_i); #1;
            update_latest(vecs[i]);
            check($sformatf("flush[%0d]", i), PAYLOAD_W'(branch_map_flush_o),
                  PAYLOAD_W'(vecs[i].exp_flush));
        end
        req_valid_i = 0;
        wait_drain();

        // Backpressure: four stored, fifth waits, then pop and push together.
        pkt_if.ready = 0;
        for (int k = 0; k < 5; k++) begin
            v = mk(2'd2, 2'd0);
            v.full_addr = 1;
            v.iaddr = 32'h100 * (k + 1);
            drive(v);
            req_valid_i = 1;
            #1;
            if (k == 4) begin
                check("full_req_ready", PAYLOAD_W'(req_ready_o), '0);
                check("full_pkt_valid", PAYLOAD_W'(pkt_if.valid), PAYLOAD_W'(1));
                pkt_if.ready = 1;
                #1 check("full_pop_push_ready", PAYLOAD_W'(req_ready_o), PAYLOAD_W'(1));
            end else begin
                check($sformatf("fill_ready[%0d]", k), PAYLOAD_W'(req_ready_o), PAYLOAD_W'(1));
            end
            expect_pkt(v, 1'b0);
            @(posedge clk_i); #1;
            update_latest(v);
        end
        req_valid_i = 0;
        wait_drain();

        // Reset with three entries queued: all lost, latest address cleared.
        pkt_if.ready = 0;
        for (int k = 0; k < 3; k++) begin
            v = mk(2'd2, 2'd0);
            v.full_addr = 1;
            v.iaddr = 32'h5000 + 32'(k);
            drive(v);
            req_valid_i = 1;
            @(posedge clk_i); #1;
        end
        req_valid_i = 0;
        check("queued_pkt_valid", PAYLOAD_W'(pkt_if.valid), PAYLOAD_W'(1));
        rst_ni = 0;
        @(posedge clk_i); #1;
        check("midrst_pkt_valid", PAYLOAD_W'(pkt_if.valid), '0);
        check("midrst_len", PAYLOAD_W'(pkt_if.len), '0);
        rst_ni = 1;
        latest_m = '0;
        pkt_if.ready = 1;
        v = mk(2'd2, 2'd0);
        v.iaddr = 32'h30;
        v.exp_len = 2;
        drive(v);
        req_valid_i = 1;
        expect_pkt(v, 1'b1);
        @(posedge clk_i); #1;
        req_valid_i = 0;
        wait_drain();

        repeat (3) @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
